// File: rtl/regfile_pkg.sv
// Shared encodings for the banked integer/FP register file: write modes,
// clear-sequencer states and bank selectors.
package regfile_pkg;

  typedef enum logic [1:0] {
    MODE_INT_W = 2'd0,  // int[rw] <= busW
    MODE_I2F   = 2'd1,  // fp[rw]  <= int[rs]
    MODE_F2I   = 2'd2,  // int[rw] <= fp[rs]
    MODE_FP_W  = 2'd3   // fp[rw]  <= busW
  } mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  typedef enum logic {
    BANK_INT = 1'b0,
    BANK_FP  = 1'b1
  } bank_e;

endpackage

// File: rtl/regfile_bank.sv
// One DEPTH x DATA_W register array with a single synchronous write port
// and two asynchronous (combinational) read ports.
module regfile_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch so it maps onto RAM/flop-array cells;
  // the top-level clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/regfile_banked.sv
// Integer + FP register file: post-reset clear sequencer, cross-bank moves,
// optional write-first bypass, optional hardwired-zero int[0], registered reads.
module regfile_banked
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic              regdst,
  input  logic [1:0]        mode,
  input  logic              rbank,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [DATA_W-1:0] busW,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] rw, waddr;
  logic [DATA_W-1:0] int_a, int_b, fp_a, fp_b, int_a_z, int_b_z;
  logic [DATA_W-1:0] wr_data, wdata, old_a, old_b, next_a, next_b;
  bank_e             wr_bank, rd_bank;
  logic              wr_en, commit_int, commit_fp, int_we, fp_we;
  logic              commit_rd, hit_a, hit_b;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset)                idx_q <= '0;
    else if (state_q == CLEAR) idx_q <= idx_q + 1'b1;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && (&idx_q)) state_d = IDLE;
  end

  always_comb begin
    busy = 1'b0;
    if (state_q == CLEAR) busy = 1'b1;
  end

  // Write decode; move sources are read combinationally, i.e. pre-edge content.
  assign rw      = regdst ? rd : rt;
  assign int_a_z = (ZERO_REG && rs == '0) ? '0 : int_a;
  assign int_b_z = (ZERO_REG && rt == '0) ? '0 : int_b;
  assign wr_en   = write && !busy;

  always_comb begin
    wr_bank = BANK_INT;
    wr_data = busW;
    case (mode_e'(mode))
      MODE_INT_W: wr_bank = BANK_INT;
      MODE_I2F:   begin wr_bank = BANK_FP; wr_data = int_a_z; end
      MODE_F2I:   wr_data = fp_a;
      MODE_FP_W:  wr_bank = BANK_FP;
      default:    wr_bank = BANK_INT;
    endcase
  end

  assign commit_int = wr_en && wr_bank == BANK_INT && !(ZERO_REG && rw == '0);
  assign commit_fp  = wr_en && wr_bank == BANK_FP;

  // The clear sequencer and normal writes share one port per bank.
  assign waddr  = busy ? idx_q : rw;
  assign wdata  = busy ? '0 : wr_data;
  assign int_we = busy ? !(ZERO_REG && idx_q == '0) : commit_int;
  assign fp_we  = busy || commit_fp;

  regfile_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_int_bank (
    .clk(clk), .we(int_we), .waddr(waddr), .wdata(wdata),
    .raddr_a(rs), .raddr_b(rt), .rdata_a(int_a), .rdata_b(int_b)
  );

  regfile_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fp_bank (
    .clk(clk), .we(fp_we), .waddr(waddr), .wdata(wdata),
    .raddr_a(rs), .raddr_b(rt), .rdata_a(fp_a), .rdata_b(fp_b)
  );

  // Bypass only from a write that actually lands in the bank being read.
  assign rd_bank   = bank_e'(rbank);
  assign commit_rd = (rd_bank == BANK_FP) ? commit_fp : commit_int;
  assign hit_a     = BYPASS && commit_rd && rw == rs;
  assign hit_b     = BYPASS && commit_rd && rw == rt;
  assign old_a     = (rd_bank == BANK_FP) ? fp_a : int_a_z;
  assign old_b     = (rd_bank == BANK_FP) ? fp_b : int_b_z;
  assign next_a    = hit_a ? wr_data : old_a;
  assign next_b    = hit_b ? wr_data : old_b;

  always_ff @(posedge clk) begin
    if (reset || busy) begin
      busA <= '0;
      busB <= '0;
    end else begin
      busA <= next_a;
      busB <= next_b;
    end
  end

endmodule

// File: tb/tb_regfile_banked.sv
// Bench for regfile_banked: a write-first and a read-old instance share
// stimulus; directed vectors plus random traffic against an array model.
module tb_regfile_banked;

  logic        clk = 1'b0;
  logic        reset, write, regdst, rbank;
  logic [1:0]  mode;
  logic [4:0]  rd, rs, rt;
  logic [31:0] busW;
  logic [31:0] busA, busB, busA_nb, busB_nb;
  logic        busy, busy_nb;

  int checks = 0;
  int failures = 0;

  logic [31:0] int_m [32];
  logic [31:0] fp_m  [32];
  logic [31:0] m_a, m_b, m_a_nb, m_b_nb;

  always #5 clk = ~clk;

  regfile_banked #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .write(write), .regdst(regdst), .mode(mode),
    .rbank(rbank), .rd(rd), .rs(rs), .rt(rt), .busW(busW),
    .busA(busA), .busB(busB), .busy(busy)
  );

  regfile_banked #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_nb (
    .clk(clk), .reset(reset), .write(write), .regdst(regdst), .mode(mode),
    .rbank(rbank), .rd(rd), .rs(rs), .rt(rt), .busW(busW),
    .busA(busA_nb), .busB(busB_nb), .busy(busy_nb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic bank, input logic [4:0] a);
    if (bank) return fp_m[a];
    return (a == 5'd0) ? 32'd0 : int_m[a];
  endfunction

  // Model: write-first instance sees contents after the write, read-old before.
  task automatic step();
    logic [4:0]  w;
    logic [31:0] src;
    m_a_nb = rd_model(rbank, rs);
    m_b_nb = rd_model(rbank, rt);
    w = regdst ? rd : rt;
    if (write) begin
      case (mode)
        2'd0: int_m[w] = busW;
        2'd1: begin src = rd_model(1'b0, rs); fp_m[w] = src; end
        2'd2: begin src = fp_m[rs]; int_m[w] = src; end
        default: fp_m[w] = busW;
      endcase
    end
    m_a = rd_model(rbank, rs);
    m_b = rd_model(rbank, rt);
    @(posedge clk); #1;
  endtask

  task automatic zero_model();
    for (int i = 0; i < 32; i++) begin
      int_m[i] = 32'd0;
      fp_m[i]  = 32'd0;
    end
  endtask

  // Counts edges from reset release until busy drops; buses must stay 0.
  task automatic wait_clear(input string name);
    int  n = 0;
    bit  zero_ok = 1'b1;
    while ((busy || busy_nb) && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy && (busA !== 0 || busB !== 0 || busA_nb !== 0 || busB_nb !== 0)) zero_ok = 1'b0;
    end
    check({name, "_len"}, n, 32);
    check({name, "_len_nb"}, busy_nb, 1'b0);
    check({name, "_bus_zero"}, {31'd0, zero_ok}, 32'd1);
    zero_model();
  endtask

  typedef struct {
    logic        wr;
    logic        dst;
    logic [1:0]  md;
    logic        bank;
    logic [4:0]  a_rd, a_rs, a_rt;
    logic [31:0] data, a, b, a_nb, b_nb;
  } vec_t;

  vec_t vecs [14];

  initial begin
    reset = 1'b1; write = 1'b0; regdst = 1'b0; mode = 2'd0; rbank = 1'b0;
    rd = '0; rs = '0; rt = '0; busW = '0;

    vecs[0]  = '{1, 1, 0, 0, 7, 7, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 7, 7, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1, 0, 0, 0, 0, 3, 3, 32'h1234, 32'h1234, 32'h1234, 0, 0};
    vecs[3]  = '{1, 0, 1, 1, 0, 3, 9, 0, 0, 32'h1234, 0, 0};
    vecs[4]  = '{1, 0, 2, 0, 0, 9, 4, 0, 0, 32'h1234, 0, 0};
    vecs[5]  = '{0, 0, 0, 1, 0, 9, 4, 0, 32'h1234, 0, 32'h1234, 0};
    vecs[6]  = '{1, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{1, 0, 3, 1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0};
    vecs[9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[10] = '{1, 1, 0, 1, 2, 2, 2, 32'h55, 0, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 2, 7, 0, 32'h55, 32'hDEADBEEF, 32'h55, 32'hDEADBEEF};
    vecs[12] = '{1, 1, 1, 1, 3, 3, 3, 0, 32'h1234, 32'h1234, 0, 0};
    vecs[13] = '{1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Garbage in every entry so the clear sequencer has something to erase.
    for (int i = 0; i < 32; i++) begin
      dut.u_int_bank.mem[i]    = $urandom();
      dut.u_fp_bank.mem[i]     = $urandom();
      dut_nb.u_int_bank.mem[i] = $urandom();
      dut_nb.u_fp_bank.mem[i]  = $urandom();
    end

    @(posedge clk); #1;
    check("reset_busA", busA, 0);
    check("reset_busB", busB, 0);
    check("reset_busy", {31'd0, busy}, 1);

    // Writes attempted during the clear must be dropped.
    reset = 1'b0; write = 1'b1; mode = 2'd0; busW = 32'hFFFFFFFF; rt = 5'd5;
    wait_clear("clear0");

    write = 1'b0; rbank = 1'b0; rs = 5'd5; rt = 5'd1; step();
    check("int5_after_clear", busA, 0);
    rbank = 1'b1; rs = 5'd31; rt = 5'd0; step();
    check("fp31_after_clear", busA, 0);
    check("fp0_after_clear", busB, 0);

    for (int i = 0; i < 14; i++) begin
      write = vecs[i].wr; regdst = vecs[i].dst; mode = vecs[i].md; rbank = vecs[i].bank;
      rd = vecs[i].a_rd; rs = vecs[i].a_rs; rt = vecs[i].a_rt; busW = vecs[i].data;
      step();
      check($sformatf("vec%0d_busA", i), busA, vecs[i].a);
      check($sformatf("vec%0d_busB", i), busB, vecs[i].b);
      check($sformatf("vec%0d_busA_nb", i), busA_nb, vecs[i].a_nb);
      check($sformatf("vec%0d_busB_nb", i), busB_nb, vecs[i].b_nb);
    end

    // Narrow address range forces frequent bypass and move collisions.
    for (int i = 0; i < 200; i++) begin
      write = 1'($urandom()); regdst = 1'($urandom()); mode = 2'($urandom());
      rbank = 1'($urandom()); busW = $urandom();
      rd = 5'($urandom_range(0, 7)); rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
      step();
      check($sformatf("rnd%0d_busA", i), busA, m_a);
      check($sformatf("rnd%0d_busB", i), busB, m_b);
      check($sformatf("rnd%0d_busA_nb", i), busA_nb, m_a_nb);
      check($sformatf("rnd%0d_busB_nb", i), busB_nb, m_b_nb);
    end

    // Reset in IDLE, then again ten cycles into the clear, with writes pending.
    reset = 1'b1; write = 1'b1; mode = 2'd3; busW = 32'hA5A5A5A5; regdst = 1'b0; rt = 5'd6;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("mid_clear_busy", {31'd0, busy}, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_clear("clear1");

    write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rbank = i[0]; rs = 5'(i); rt = 5'(31 - i);
      step();
      check($sformatf("sweep%0d_busA", i), busA, m_a);
      check($sformatf("sweep%0d_busB", i), busB_nb, m_b);
    end
    check("idle_busy", {31'd0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_banked.md
Name: regfile_banked

Overview:
Parametrised successor to the single-cycle integer/FP register file. It holds an integer bank and an FP bank, each DEPTH = 2**ADDR_W entries of DATA_W bits. It provides two registered read ports, one write port with cross-bank move modes, configurable write-to-read bypass and an optional hardwired zero register. A post-reset clear sequencer zeroes both banks, so the design does not rely on simulation-only initial blocks. It sits between decode and the ALU/FPU in the single-cycle datapath.

Parameters:
DATA_W, 32, bits per register
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
BYPASS, 1, 1 = write-first (read returns same-cycle write data); 0 = read-old
ZERO_REG, 1, 1 = integer entry 0 reads 0 and ignores writes; FP bank unaffected

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
write  in  1  write enable, sampled at posedge
regdst  in  1  destination select: 0 = rt, 1 = rd
mode  in  2  0: int[rw]<=busW; 1: fp[rw]<=int[rs]; 2: int[rw]<=fp[rs]; 3: fp[rw]<=busW
rbank  in  1  read bank for both ports: 0 = int, 1 = fp
rd  in  ADDR_W  destination address when regdst=1
rs  in  ADDR_W  read port A address; move source address
rt  in  ADDR_W  read port B address; destination address when regdst=0
busW  in  DATA_W  write data for modes 0 and 3
busA  out  DATA_W  registered read data, port A
busB  out  DATA_W  registered read data, port B
busy  out  1  high while the clear sequence runs

Behaviour:
- FSM states CLEAR and IDLE. Reset forces CLEAR with idx=0, busy=1, busA=busB=0.
- CLEAR: each cycle writes 0 to int[idx] and fp[idx], then idx increments. When idx=DEPTH-1, the state moves to IDLE and busy=0 on the following edge. The sequence takes exactly DEPTH cycles after reset deasserts.
- During CLEAR: write is ignored, busA/busB are held at 0, and rbank/rs/rt are don't-care.
- Reset asserted during CLEAR restarts at idx=0. Reset during IDLE re-enters CLEAR, and all contents are re-zeroed.
- IDLE write: rw = regdst ? rd : rt. Effect is per mode. For moves, the source value is the pre-edge content of the other bank at rs.
- Read: at posedge, busA <= bank[rbank][rs] and busB <= bank[rbank][rt]. Latency is 1 cycle from address to bus.
- BYPASS=1: if write is active and the destination bank equals rbank and rw equals rs (or rt), that port gets the written value (busW, or the move source), not the old content.
- BYPASS=0: the port gets the old content; the new value is visible from the next read.
- ZERO_REG=1: writes to int[0] are dropped, including the clear write and mode 2. An int-bank read of address 0 returns 0, and bypass never overrides this. FP entry 0 is a normal register.
- rs=rt with both ports reading the same bank: both buses return the identical value.
- Moves with rs == rw (same index, other bank) are legal; the source is the old value of the other bank.
- No X on busA/busB at any point after the first reset edge.

Decomposition:
- Package regfile_pkg: mode encodings MODE_INT_W=0, MODE_I2F=1, MODE_F2I=2, MODE_FP_W=3; state encoding CLEAR/IDLE; bank encodings BANK_INT=0, BANK_FP=1.
- One sub-module: regfile_bank (single DEPTH x DATA_W array, one write port, two combinational read ports, instantiated twice).
- Top level holds the FSM, the move/bypass muxing and the output registers.

Test Plan:
- Reset 1 cycle, then idle; pre-load garbage via backdoor → busy high for exactly 32 cycles. After that, reads of int[5] and fp[31] return 0.
- IDLE, mode=0, regdst=1, rd=7, busW=0xDEADBEEF, rs=7, rbank=0, BYPASS=1 → busA=0xDEADBEEF next edge. With BYPASS=0, the old value 0 appears first, then 0xDEADBEEF one cycle later.
- int[3]=0x1234, mode=1, regdst=0, rt=9, rs=3 → fp[9]=0x1234. Then mode=2, rs=9, rt=4 → int[4]=0x1234. Finally rbank=1, rs=9 → busA=0x1234.
- ZERO_REG=1: mode=0, rt=0, regdst=0, busW=0xFFFFFFFF → int-bank read of rs=0 gives 0. Same sequence with mode=3 → fp[0] reads 0xFFFFFFFF.
- Assert reset at clear cycle 10; also issue write=1 during CLEAR → idx restarts at 0 and busy lasts 32 more cycles. The write is dropped, and all entries read 0 afterwards.
- rbank=1 with mode=0 writing int[2] and rs=2 → busA shows fp[2] (old content); the bank mismatch means no bypass.
